spi_bus_scheduler: RTL and testbench
====================================

SPI_BUS_SCHEDULER -- requirements
Module: spi_bus_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one clock_divider (legal range 2..8).
REQ-002 Parameter TIMEOUT, default 4096, SHALL set the number of cycles any divider-wait state may last before abort.
REQ-003 i_clk  in  1  SHALL be the single clock; every register is updated on its rising edge.
REQ-004 i_rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 i_req  in  N_REQ  SHALL carry one request bit per requester.
REQ-006 i_cdiv  in  8*N_REQ  SHALL carry the divisor of requester k in bits [8k+7:8k].
REQ-007 o_grant  out  N_REQ  SHALL be one-hot for the owner, or zero.
REQ-008 o_busy  out  1  SHALL be high in every state except IDLE.
REQ-009 o_done  out  1  SHALL pulse for one cycle at the end of a transaction.
REQ-010 o_error  out  1  SHALL be qualified by o_done; 1 means rejected or aborted.
REQ-011 o_div_config  out  9  SHALL drive the divider config: [8:1] divisor, [0] load strobe.
REQ-012 o_div_start_n  out  1  SHALL be the active-low divider start.
REQ-013 i_div_ready  in  1  SHALL be the divider ready flag.

Function
REQ-014 States SHALL be IDLE, CHECK, CFG, CFG_WAIT, START, RUN_WAIT and FINISH.
REQ-015 IDLE: with i_req!=0, the FSM SHALL latch the winner index and its divisor, set o_grant next cycle, and go to CHECK.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod N_REQ, ascending with wrap; last_owner updates in FINISH.
REQ-017 CHECK: a divisor that is 0 or odd SHALL go to FINISH with error; one equal to a valid cached divisor SHALL go to START; any other SHALL go to CFG.
REQ-018 CFG: o_div_config[0] SHALL be 1 for exactly one cycle, the first CFG cycle with i_div_ready=1, then the FSM SHALL go to CFG_WAIT.
REQ-019 CFG_WAIT: the FSM SHALL go to START on the first i_div_ready=1 cycle that follows at least one i_div_ready=0 cycle, and SHALL load the cache (marked valid) with the divisor.
REQ-020 START: o_div_start_n SHALL be 0 for exactly one cycle, the first START cycle with i_div_ready=1; o_div_config[0] SHALL be 0 then; then the FSM SHALL go to RUN_WAIT.
REQ-021 RUN_WAIT: the FSM SHALL go to FINISH, error=0, on ready rising after at least one ready-low cycle.
REQ-022 FINISH: the block SHALL assert o_done for one cycle, hold o_grant during that cycle, clear o_grant next cycle, and return to IDLE.
REQ-023 o_div_config[8:1] SHALL equal the latched divisor from CHECK through FINISH and 0 otherwise.
REQ-024 o_div_config[0] and o_div_start_n=0 SHALL never be asserted in the same cycle.
REQ-025 A 13-bit wait counter SHALL clear on each state entry and count in CFG, CFG_WAIT, START and RUN_WAIT.
REQ-026 When the counter reaches TIMEOUT-1, the FSM SHALL go to FINISH with error=1 and invalidate the cache.
REQ-027 i_req changes after the latch in IDLE SHALL be ignored until FINISH, and the transaction SHALL complete.
REQ-028 A requester still requesting after its own done SHALL re-enter arbitration at lowest priority.
REQ-029 Minimum latency with a cache hit and ready held high, excluding divider run time, SHALL be request-to-start_n-low = 3 cycles.

Reset
REQ-030 While i_rst=1, and on the first cycle after it: state=IDLE, o_grant=0, o_busy=0, o_done=0, o_error=0, o_div_config=0, o_div_start_n=1, cache invalid, last_owner=N_REQ-1.
REQ-031 Reset mid-transaction SHALL abort without o_done, and outputs SHALL hold reset values from the next edge.

Verification
REQ-032 Bench: i_req=0001, i_cdiv[7:0]=8, divider model -> config=0x011 one cycle, then start_n low one cycle, then done=1 with error=0.
REQ-033 Bench: repeat req0 with cdiv=8 -> no config strobe (cache hit), start_n low 3 cycles after the request.
REQ-034 Bench: i_req=1111 held -> grants in the order 0001, 0010, 0100, 1000, 0001, with no overlap.
REQ-035 Bench: cdiv=7 or 0 -> no divider strobes, done=1, error=1 within 3 cycles of grant.
REQ-036 Bench: i_div_ready held 0 -> done=1 with error=1 after 4096 wait cycles, and the next request with the same divisor reconfigures.
REQ-037 Bench: i_rst=1 during RUN_WAIT -> next edge grant=0, busy=0, start_n=1, and no done pulse.

Source files
------------

// File: rtl/spi_bus_scheduler.sv
// Round-robin scheduler that shares one SPI clock divider among N_REQ requesters.
// Reconfiguration is skipped when the granted divisor matches the cached one.
module spi_bus_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_cdiv,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [8:0]           o_div_config,
    output logic                 o_div_start_n,
    input  logic                 i_div_ready
);

    localparam int          IW       = $clog2(N_REQ);
    localparam int unsigned NR       = N_REQ;
    localparam logic [12:0] CNT_LAST = 13'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CFG,
        S_CFG_WAIT,
        S_START,
        S_RUN_WAIT,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_last;
    logic [7:0]        r_div;
    logic [7:0]        r_cache_div;
    logic              r_cache_vld;
    logic              r_err;
    logic [N_REQ-1:0]  r_grant;
    logic [12:0]       r_cnt;
    logic              r_seen_low;

    logic              w_win_vld;
    logic [IW-1:0]     w_win_idx;
    logic [7:0]        w_win_div;
    logic              w_err_next;
    logic              w_cache_load;
    logic              w_cache_inval;
    logic              w_timeout;
    logic              w_waiting;
    logic              w_bad_div;
    logic              w_hit;
    int unsigned       w_k;

    // Search begins one past the previous owner so a persistent requester goes last.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_win_div = '0;
        w_k       = 0;
        for (int unsigned i = 1; i <= NR; i++) begin
            w_k = (32'(r_last) + i) % NR;
            if (!w_win_vld && (((i_req >> w_k) & N_REQ'(1)) != '0)) begin
                w_win_vld = 1'b1;
                w_win_idx = IW'(w_k);
                w_win_div = 8'(i_cdiv >> (8 * w_k));
            end
        end
    end

    assign w_waiting = (r_state == S_CFG) || (r_state == S_CFG_WAIT) ||
                       (r_state == S_START) || (r_state == S_RUN_WAIT);
    assign w_timeout = w_waiting && (r_cnt == CNT_LAST);
    assign w_bad_div = (r_div == 8'd0) || r_div[0];
    assign w_hit     = r_cache_vld && (r_cache_div == r_div);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Divider progress wins over the timeout when both happen in the same cycle.
    always_comb begin
        w_next        = r_state;
        w_err_next    = r_err;
        w_cache_load  = 1'b0;
        w_cache_inval = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_next     = S_CHECK;
                    w_err_next = 1'b0;
                end
            end
            S_CHECK: begin
                if (w_bad_div) begin
                    w_next     = S_FINISH;
                    w_err_next = 1'b1;
                end else if (w_hit) begin
                    w_next = S_START;
                end else begin
                    w_next = S_CFG;
                end
            end
            S_CFG: begin
                if (i_div_ready) begin
                    w_next = S_CFG_WAIT;
                end else if (w_timeout) begin
                    w_next        = S_FINISH;
                    w_err_next    = 1'b1;
                    w_cache_inval = 1'b1;
                end
            end
            S_CFG_WAIT: begin
                if (i_div_ready && r_seen_low) begin
                    w_next       = S_START;
                    w_cache_load = 1'b1;
                end else if (w_timeout) begin
                    w_next        = S_FINISH;
                    w_err_next    = 1'b1;
                    w_cache_inval = 1'b1;
                end
            end
            S_START: begin
                if (i_div_ready) begin
                    w_next = S_RUN_WAIT;
                end else if (w_timeout) begin
                    w_next        = S_FINISH;
                    w_err_next    = 1'b1;
                    w_cache_inval = 1'b1;
                end
            end
            S_RUN_WAIT: begin
                if (i_div_ready && r_seen_low) begin
                    w_next     = S_FINISH;
                    w_err_next = 1'b0;
                end else if (w_timeout) begin
                    w_next        = S_FINISH;
                    w_err_next    = 1'b1;
                    w_cache_inval = 1'b1;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner     <= '0;
            r_last      <= IW'(N_REQ - 1);
            r_div       <= '0;
            r_cache_div <= '0;
            r_cache_vld <= 1'b0;
            r_err       <= 1'b0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_seen_low  <= 1'b0;
        end else begin
            r_err <= w_err_next;
            if (w_next != r_state) begin
                r_cnt      <= '0;
                r_seen_low <= 1'b0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 13'd1;
                if (!i_div_ready) begin
                    r_seen_low <= 1'b1;
                end
            end
            if (r_state == S_IDLE && w_win_vld) begin
                r_owner <= w_win_idx;
                r_div   <= w_win_div;
                r_grant <= N_REQ'(1) << w_win_idx;
            end
            if (r_state == S_FINISH) begin
                r_grant <= '0;
                r_last  <= r_owner;
            end
            if (w_cache_load) begin
                r_cache_div <= r_div;
                r_cache_vld <= 1'b1;
            end else if (w_cache_inval) begin
                r_cache_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        o_grant       = r_grant;
        o_busy        = (r_state != S_IDLE);
        o_done        = (r_state == S_FINISH);
        o_error       = (r_state == S_FINISH) && r_err;
        o_div_config  = '0;
        o_div_start_n = 1'b1;
        if (r_state != S_IDLE) begin
            o_div_config[8:1] = r_div;
        end
        if (r_state == S_CFG && i_div_ready) begin
            o_div_config[0] = 1'b1;
        end
        if (r_state == S_START && i_div_ready) begin
            o_div_start_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Directed bench for spi_bus_scheduler with a small divider model that drops
// ready for three cycles after each config strobe or start pulse.
module tb_spi_bus_scheduler;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_req = '0;
    logic [31:0] i_cdiv = '0;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [8:0]  o_div_config;
    logic        o_div_start_n;
    logic        rdy = 1'b1;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          stuck = 1'b0;
    int          mdl_cnt = 0;

    int          cfg_cnt, start_cnt, start_cyc, grant_cyc, done_cyc, overlap;
    logic [8:0]  cfg_val;
    logic        done_seen, done_err, post_busy;
    logic [3:0]  done_grant, first_grant, post_grant;

    spi_bus_scheduler #(.N_REQ(4), .TIMEOUT(4096)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_cdiv        (i_cdiv),
        .o_grant       (o_grant),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_div_config  (o_div_config),
        .o_div_start_n (o_div_start_n),
        .i_div_ready   (rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stuck) begin
            rdy     <= 1'b0;
            mdl_cnt <= 0;
        end else if (i_rst) begin
            rdy     <= 1'b1;
            mdl_cnt <= 0;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            rdy     <= (mdl_cnt == 1);
        end else if (o_div_config[0] || !o_div_start_n) begin
            mdl_cnt <= 3;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(o_grant), 32'h0);
        check({tag, "_busy"}, 32'(o_busy), 32'h0);
        check({tag, "_done"}, 32'(o_done), 32'h0);
        check({tag, "_error"}, 32'(o_error), 32'h0);
        check({tag, "_cfg"}, 32'(o_div_config), 32'h0);
        check({tag, "_start_n"}, 32'(o_div_start_n), 32'h1);
    endtask

    // Cycle 1 is the cycle in which the request is first presented.
    task automatic run_txn(input logic [3:0] req, input logic [31:0] cdiv,
                           input logic [3:0] mid_req, input int limit);
        int cyc;
        i_cdiv      = cdiv;
        i_req       = req;
        cfg_cnt     = 0;
        start_cnt   = 0;
        start_cyc   = 0;
        grant_cyc   = 0;
        done_cyc    = 0;
        cfg_val     = '0;
        done_seen   = 1'b0;
        done_err    = 1'b0;
        done_grant  = '0;
        first_grant = '0;
        cyc         = 1;
        while (!done_seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (o_div_config[0]) begin
                cfg_cnt++;
                cfg_val = o_div_config;
            end
            if (!o_div_start_n) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (o_div_config[0] && !o_div_start_n) overlap++;
            if (o_grant != '0 && grant_cyc == 0) begin
                grant_cyc   = cyc;
                first_grant = o_grant;
            end
            if (o_done) begin
                done_seen  = 1'b1;
                done_err   = o_error;
                done_grant = o_grant;
                done_cyc   = cyc;
            end
            if (cyc == 2) i_req = mid_req;
        end
        i_req = '0;
        @(negedge clk);
        post_busy  = o_busy;
        post_grant = o_grant;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        i_req = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seq [5];
        logic [3:0] prev;
        int         ng;
        int         bad;
        int         waited;
        overlap = 0;

        // Reset values while asserted and on the first cycle after release
        repeat (2) @(negedge clk);
        check_idle("rst_held");
        i_rst = 1'b0;
        @(negedge clk);
        check_idle("rst_after");

        // Round-robin with all four requesting from a fresh reset
        i_cdiv = {8'd10, 8'd6, 8'd4, 8'd8};
        i_req  = 4'b1111;
        ng = 0;
        bad = 0;
        prev = '0;
        for (int c = 0; c < 600 && ng < 5; c++) begin
            @(negedge clk);
            if (o_grant != '0 && !$onehot(o_grant)) bad++;
            if (o_grant != '0 && prev == '0) begin
                seq[ng] = o_grant;
                ng++;
            end
            prev = o_grant;
        end
        i_req = '0;
        waited = 0;
        while (o_busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("rr_count", 32'(ng), 32'd5);
        check("rr_g0", 32'(seq[0]), 32'h1);
        check("rr_g1", 32'(seq[1]), 32'h2);
        check("rr_g2", 32'(seq[2]), 32'h4);
        check("rr_g3", 32'(seq[3]), 32'h8);
        check("rr_g4", 32'(seq[4]), 32'h1);
        check("rr_onehot_bad", 32'(bad), 32'd0);
        check("rr_idle_after", 32'(o_busy), 32'h0);

        // Cold cache: config strobe, start pulse, clean done
        do_reset();
        run_txn(4'b0001, 32'h0000_0008, 4'b0001, 200);
        check("miss_done", 32'(done_seen), 32'h1);
        check("miss_err", 32'(done_err), 32'h0);
        check("miss_cfg_cnt", 32'(cfg_cnt), 32'd1);
        check("miss_cfg_val", 32'(cfg_val), 32'h011);
        check("miss_start_cnt", 32'(start_cnt), 32'd1);
        check("miss_done_grant", 32'(done_grant), 32'h1);
        check("miss_post_grant", 32'(post_grant), 32'h0);
        check("miss_post_busy", 32'(post_busy), 32'h0);

        // Cache hit, request dropped right after the latch
        run_txn(4'b0001, 32'h0000_0008, 4'b0000, 200);
        check("hit_done", 32'(done_seen), 32'h1);
        check("hit_cfg_cnt", 32'(cfg_cnt), 32'd0);
        check("hit_start_cyc", 32'(start_cyc), 32'd3);
        check("hit_grant", 32'(first_grant), 32'h1);
        check("hit_done_grant", 32'(done_grant), 32'h1);
        check("hit_err", 32'(done_err), 32'h0);

        // Odd and zero divisors are rejected without touching the divider
        run_txn(4'b0010, 32'h0000_0700, 4'b0010, 50);
        check("odd_done", 32'(done_seen), 32'h1);
        check("odd_err", 32'(done_err), 32'h1);
        check("odd_strobes", 32'(cfg_cnt + start_cnt), 32'd0);
        check("odd_latency", 32'((done_cyc - grant_cyc) <= 3), 32'h1);
        check("odd_grant", 32'(done_grant), 32'h2);
        run_txn(4'b0100, 32'h0000_0000, 4'b0100, 50);
        check("zero_done", 32'(done_seen), 32'h1);
        check("zero_err", 32'(done_err), 32'h1);
        check("zero_strobes", 32'(cfg_cnt + start_cnt), 32'd0);
        check("zero_latency", 32'((done_cyc - grant_cyc) <= 3), 32'h1);

        // Divider stuck not-ready: cache hit lands in START and times out there
        stuck = 1'b1;
        @(negedge clk);
        run_txn(4'b0001, 32'h0000_0008, 4'b0001, 4300);
        check("to_done", 32'(done_seen), 32'h1);
        check("to_err", 32'(done_err), 32'h1);
        check("to_span", 32'(done_cyc - grant_cyc), 32'd4097);
        check("to_strobes", 32'(cfg_cnt + start_cnt), 32'd0);
        stuck = 1'b0;
        repeat (2) @(negedge clk);

        // Same divisor after a timeout must reconfigure
        run_txn(4'b0001, 32'h0000_0008, 4'b0001, 200);
        check("recfg_done", 32'(done_seen), 32'h1);
        check("recfg_cfg_cnt", 32'(cfg_cnt), 32'd1);
        check("recfg_err", 32'(done_err), 32'h0);

        // Reset in RUN_WAIT aborts silently
        i_cdiv = 32'h0000_0008;
        i_req  = 4'b0001;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (o_div_start_n && waited < 20);
        check("rw_start_seen", 32'(o_div_start_n), 32'h0);
        @(negedge clk);
        check("rw_busy_before", 32'(o_busy), 32'h1);
        i_rst = 1'b1;
        i_req = '0;
        bad = 0;
        @(negedge clk);
        check("rw_grant", 32'(o_grant), 32'h0);
        check("rw_busy", 32'(o_busy), 32'h0);
        check("rw_start_n", 32'(o_div_start_n), 32'h1);
        if (o_done) bad++;
        repeat (3) begin
            @(negedge clk);
            if (o_done) bad++;
        end
        i_rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (o_done) bad++;
        end
        check("rw_no_done", 32'(bad), 32'd0);

        check("cfg_start_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
